// File: rtl/fitness_evaluator.sv
// Fitness stage for the evolvable LE array: walks every input vector, lets the array
// settle, and counts output bits that agree with a latched target truth table.
module fitness_evaluator #(
    parameter  int IN     = 2,
    parameter  int OUT    = 1,
    parameter  int SETTLE = 1,
    localparam int FIT_W  = $clog2(OUT * 2**IN + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [OUT*(2**IN)-1:0]  target,
    output logic [IN-1:0]           inp_o,
    input  logic [OUT-1:0]          circ_out,
    output logic                    busy,
    output logic                    done,
    output logic [FIT_W-1:0]        fitness,
    output logic                    perfect
);

    localparam int NVEC  = 2**IN;
    localparam int TT_W  = OUT * NVEC;
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_APPLY,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [TT_W-1:0]    tgt_q, tgt_d;
    logic [IN-1:0]      vec_q, vec_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [FIT_W-1:0]   acc_q, acc_d;
    logic [FIT_W-1:0]   fit_q, fit_d;
    logic               perf_q, perf_d;

    logic [OUT-1:0]     tgt_slice;
    logic [FIT_W-1:0]   match_cnt;
    logic [FIT_W-1:0]   sum;

    assign tgt_slice = tgt_q[vec_q*OUT +: OUT];

    // Number of output bits of the current vector that agree with the target.
    always_comb begin
        match_cnt = '0;
        for (int unsigned k = 0; k < OUT; k++) begin
            if (circ_out[k] == tgt_slice[k]) begin
                match_cnt = match_cnt + FIT_W'(1);
            end
        end
    end

    assign sum = acc_q + match_cnt;

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        fit_d   = fit_q;
        perf_d  = perf_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    tgt_d   = target;
                    vec_d   = '0;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = S_APPLY;
                end
            end
            S_APPLY: begin
                if (cnt_q == CNT_W'(SETTLE - 1)) begin
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_SAMPLE: begin
                // Last vector is detected by value; vec never wraps back to 0.
                if (vec_q == '1) begin
                    fit_d   = sum;
                    perf_d  = (sum == FIT_W'(TT_W));
                    state_d = S_DONE;
                end else begin
                    acc_d   = sum;
                    vec_d   = vec_q + IN'(1);
                    cnt_d   = '0;
                    state_d = S_APPLY;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            tgt_q   <= '0;
            vec_q   <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            fit_q   <= '0;
            perf_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            fit_q   <= fit_d;
            perf_q  <= perf_d;
        end
    end

    // The vector register doubles as the array drive, so inp_o tracks vec exactly.
    assign inp_o   = vec_q;
    assign busy    = (state_q == S_APPLY) || (state_q == S_SAMPLE);
    assign done    = (state_q == S_DONE);
    assign fitness = fit_q;
    assign perfect = perf_q;

endmodule
